pixel_frame_ingest: RTL and testbench

- Parametrised image-ingest front end for the digit-recognition datapath.
- Accepts a raw pixel stream with a valid/ready handshake and optional binarisation.
- Stores each frame in one of two ping-pong banks and presents a committed frame to the classifier through a random-access read port.
- Replaces free-running "one pixel per cycle" feeding with back-pressure, framing checks and double buffering.

---
 rtl/pixel_frame_ingest.sv | 151 +++++++++++++++
 tb/tb_pixel_frame_ingest.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_ingest.sv
// Image-ingest front end: accepts a pixel stream under valid/ready, optionally
// binarises each pixel, fills one of two ping-pong banks and exposes the most
// recently committed bank to the classifier through a registered read port.
module pixel_frame_ingest #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  in_data,
    input  logic              in_last,
    input  logic              bin_en,
    input  logic [PIX_W-1:0]  bin_thresh,
    output logic              frame_valid,
    input  logic              frame_release,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data,
    output logic              frame_err,
    output logic [15:0]       frame_cnt
);

    localparam int N_PIX = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(2 * N_PIX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    localparam logic FILL      = 1'b0;
    localparam logic ERR_DRAIN = 1'b1;

    logic              state_reg, state_next;
    logic [ADDR_W-1:0] wp_reg, wp_next;
    logic              wb_reg;
    logic              rb_reg;
    logic [1:0]        full_reg, full_next;
    logic              frame_err_reg, frame_err_next;
    logic [15:0]       frame_cnt_reg;
    logic [PIX_W-1:0]  rd_data_reg;

    // Both banks live in one array; bank 1 starts at word N_PIX.
    logic [PIX_W-1:0]  mem [0:2*N_PIX-1];

    logic              accept;
    logic              at_end;
    logic              commit;
    logic              release_ok;
    logic              wr_en;
    logic [PIX_W-1:0]  wr_data;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    // Ready depends only on registered flags, never on in_valid.
    assign in_ready    = !full_reg[wb_reg];
    assign frame_valid = full_reg[rb_reg];
    assign frame_err   = frame_err_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign rd_data     = rd_data_reg;

    assign accept     = in_valid && in_ready;
    assign at_end     = (wp_reg == LAST_ADDR);
    assign commit     = accept && (state_reg == FILL) && at_end && in_last;
    assign release_ok = frame_release && full_reg[rb_reg];
    // Pixels seen while draining a long frame are discarded, not stored.
    assign wr_en      = accept && (state_reg == FILL);
    assign wr_data    = bin_en ? {PIX_W{in_data >= bin_thresh}} : in_data;
    assign wr_idx     = wb_reg ? IDX_W'(N_PIX) + IDX_W'(wp_reg) : IDX_W'(wp_reg);
    assign rd_idx     = rb_reg ? IDX_W'(N_PIX) + IDX_W'(rd_addr) : IDX_W'(rd_addr);

    // Per-bank flag update: commit sets the write bank, release clears the
    // read bank; the two can never hit the same bank in one cycle.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign full_next[gi] = (commit && (wb_reg == 1'(gi))) ||
                                   (full_reg[gi] && !(release_ok && (rb_reg == 1'(gi))));
        end
    endgenerate

    // Framing FSM: tracks the write pointer and detects short/long frames.
    always_comb begin
        state_next     = state_reg;
        wp_next        = wp_reg;
        frame_err_next = 1'b0;
        if (accept) begin
            case (state_reg)
                FILL: begin
                    if (in_last) begin
                        wp_next        = '0;
                        frame_err_next = !at_end;
                    end else if (at_end) begin
                        wp_next        = '0;
                        frame_err_next = 1'b1;
                        state_next     = ERR_DRAIN;
                    end else begin
                        wp_next = wp_reg + ADDR_W'(1);
                    end
                end
                ERR_DRAIN: begin
                    if (in_last) begin
                        state_next = FILL;
                        wp_next    = '0;
                    end
                end
                default: state_next = FILL;
            endcase
        end
    end

    // Control registers: FSM, pointers, bank flags and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            wp_reg        <= '0;
            wb_reg        <= 1'b0;
            rb_reg        <= 1'b0;
            full_reg      <= 2'b00;
            frame_err_reg <= 1'b0;
            frame_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            wp_reg        <= wp_next;
            full_reg      <= full_next;
            frame_err_reg <= frame_err_next;
            if (commit) begin
                wb_reg        <= !wb_reg;
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
            if (release_ok) begin
                rb_reg <= !rb_reg;
            end
        end
    end

    // Pixel store write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read port into the current read bank, one cycle latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_pixel_frame_ingest.sv
// Self-checking bench for pixel_frame_ingest. A frame-level model (a FIFO of
// committed frames plus the frame currently being assembled) predicts errors,
// frame counts and read-back contents.
module tb_pixel_frame_ingest;

    localparam int PIX_W  = 8;
    localparam int IMG_W  = 28;
    localparam int IMG_H  = 28;
    localparam int N_PIX  = IMG_W * IMG_H;
    localparam int ADDR_W = 10;

    typedef logic [PIX_W-1:0] pix_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    pix_t              in_data = '0;
    logic              in_last = 1'b0;
    logic              bin_en = 1'b0;
    pix_t              bin_thresh = '0;
    logic              frame_valid;
    logic              frame_release = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    pix_t              rd_data;
    logic              frame_err;
    logic [15:0]       frame_cnt;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    pixel_frame_ingest #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .bin_en       (bin_en),
        .bin_thresh   (bin_thresh),
        .frame_valid  (frame_valid),
        .frame_release(frame_release),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_err    (frame_err),
        .frame_cnt    (frame_cnt)
    );

    // ---------------- reference model ----------------
    pix_t fq [4][N_PIX];
    int   fq_head  = 0;
    int   fq_count = 0;
    pix_t cur [N_PIX];
    int   cur_len  = 0;
    bit   draining = 0;
    int   exp_cnt  = 0;

    function automatic void model_reset();
        fq_head  = 0;
        fq_count = 0;
        cur_len  = 0;
        draining = 0;
        exp_cnt  = 0;
    endfunction

    function automatic void model_release();
        if (fq_count > 0) begin
            fq_head  = (fq_head + 1) % 4;
            fq_count = fq_count - 1;
        end
    endfunction

    // Returns 1 when this pixel should raise frame_err.
    function automatic bit model_accept(pix_t d, bit last, bit en, pix_t th);
        int slot;
        if (draining) begin
            if (last) draining = 0;
            return 0;
        end
        cur[cur_len] = en ? ((d >= th) ? 8'hFF : 8'h00) : d;
        cur_len = cur_len + 1;
        if (last && cur_len == N_PIX) begin
            slot = (fq_head + fq_count) % 4;
            for (int i = 0; i < N_PIX; i++) fq[slot][i] = cur[i];
            fq_count = fq_count + 1;
            exp_cnt  = (exp_cnt + 1) % 65536;
            cur_len  = 0;
            return 0;
        end
        if (last) begin
            cur_len = 0;
            return 1;
        end
        if (cur_len == N_PIX) begin
            cur_len  = 0;
            draining = 1;
            return 1;
        end
        return 0;
    endfunction

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic send(input pix_t d, input bit last, input bit rel);
        int guard;
        bit e;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                checks++;
                fails++;
                $display("FAIL send_stall in_ready=%b required 1", in_ready);
                in_valid = 1'b0;
                return;
            end
        end
        frame_release = rel;
        if (rel && fq_count > 0) model_release();
        e = model_accept(d, last, bin_en, bin_thresh);
        @(posedge clk);
        @(negedge clk);
        in_valid      = 1'b0;
        frame_release = 1'b0;
        checks++;
        if (frame_err !== e) begin
            fails++;
            $display("FAIL frame_err got=%b required=%b (data=%h last=%b)", frame_err, e, d, last);
        end
    endtask

    // mode 0: value = index mod 256; 1: random data with stalls; 2: also random binarisation
    task automatic send_frame(input int n, input int mode, input bit rel_last);
        pix_t d;
        for (int i = 0; i < n; i++) begin
            if (mode != 0 && $urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                in_data  = pix_t'($urandom);
                @(negedge clk);
            end
            if (mode == 2) begin
                bin_en     = 1'($urandom_range(0, 1));
                bin_thresh = pix_t'($urandom);
            end
            d = (mode == 0) ? pix_t'(i) : pix_t'($urandom);
            send(d, i == n - 1, rel_last && (i == n - 1));
        end
        bin_en = 1'b0;
    endtask

    task automatic check_frame(input string name);
        checks++;
        if (frame_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid frame_valid=%b required 1", name, frame_valid);
        end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL %s_cnt frame_cnt=%0d required %0d", name, frame_cnt, exp_cnt);
        end
        if (fq_count > 0) begin
            for (int a = 0; a < N_PIX; a++) begin
                rd_addr = ADDR_W'(a);
                @(negedge clk);
                checks++;
                if (rd_data !== fq[fq_head][a]) begin
                    fails++;
                    $display("FAIL %s_data addr=%0d rd_data=%h required %h", name, a, rd_data, fq[fq_head][a]);
                end
            end
        end
    endtask

    task automatic release_frame(input string name);
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
        model_release();
        checks++;
        if (frame_valid !== (fq_count > 0)) begin
            fails++;
            $display("FAIL %s_release frame_valid=%b required %b", name, frame_valid, fq_count > 0);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got=%b required 1", name, in_ready); end
        checks++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL %s_frame_valid got=%b required 0", name, frame_valid); end
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL %s_frame_err got=%b required 0", name, frame_err); end
        checks++;
        if (rd_data !== 8'h00) begin fails++; $display("FAIL %s_rd_data got=%h required 00", name, rd_data); end
        checks++;
        if (frame_cnt !== 16'd0) begin fails++; $display("FAIL %s_frame_cnt got=%0d required 0", name, frame_cnt); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        release_frame("idle");   // release with nothing committed is ignored
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        for (int i = 0; i < N_PIX - 1; i++) send(pix_t'(i), 1'b0, 1'b0);
        checks++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL single_early frame_valid=%b required 0", frame_valid); end
        send(pix_t'(N_PIX - 1), 1'b1, 1'b0);
        checks++;
        if (frame_valid !== 1'b1) begin fails++; $display("FAIL single_valid frame_valid=%b required 1", frame_valid); end
        checks++;
        if (frame_cnt !== 16'd1) begin fails++; $display("FAIL single_cnt frame_cnt=%0d required 1", frame_cnt); end
        rd_addr = ADDR_W'(300);
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h2C) begin fails++; $display("FAIL single_addr300 rd_data=%h required 2c", rd_data); end
        check_frame("single");
        release_frame("single");
        $display("test_single_frame done");
    endtask

    task automatic test_back_to_back();
        send_frame(N_PIX, 1, 1'b0);
        send_frame(N_PIX, 1, 1'b0);
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL b2b_cnt frame_cnt=%0d required %0d", frame_cnt, exp_cnt); end
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall cycle=%0d in_ready=%b required 0", c, in_ready); end
            @(negedge clk);
        end
        frame_release = 1'b1;
        @(negedge clk);
        frame_release = 1'b0;
        in_valid      = 1'b0;
        model_release();
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_release in_ready=%b required 1", in_ready); end
        check_frame("b2b_frame2");
        send_frame(N_PIX, 1, 1'b0);
        release_frame("b2b_frame2");
        check_frame("b2b_frame3");
        // Release frame 3 in the same cycle as frame 4 commits.
        send_frame(N_PIX, 1, 1'b1);
        check_frame("b2b_frame4");
        release_frame("b2b_frame4");
        $display("test_back_to_back done");
    endtask

    task automatic test_binarise();
        pix_t d;
        bin_en     = 1'b1;
        bin_thresh = 8'h80;
        for (int i = 0; i < N_PIX; i++) begin
            d = (i == 0) ? 8'h7F : (i == 1) ? 8'h80 : pix_t'($urandom);
            send(d, i == N_PIX - 1, 1'b0);
        end
        bin_en = 1'b0;
        rd_addr = ADDR_W'(0);
        @(negedge clk);
        checks++;
        if (rd_data !== 8'h00) begin fails++; $display("FAIL bin_7f rd_data=%h required 00", rd_data); end
        rd_addr = ADDR_W'(1);
        @(negedge clk);
        checks++;
        if (rd_data !== 8'hFF) begin fails++; $display("FAIL bin_80 rd_data=%h required ff", rd_data); end
        check_frame("bin");
        release_frame("bin");
        $display("test_binarise done");
    endtask

    task automatic test_short_frame();
        send_frame(500, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL short_pulse frame_err=%b required 0", frame_err); end
        checks++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL short_valid frame_valid=%b required 0", frame_valid); end
        checks++;
        if (frame_cnt !== 16'(exp_cnt)) begin fails++; $display("FAIL short_cnt frame_cnt=%0d required %0d", frame_cnt, exp_cnt); end
        send_frame(N_PIX, 1, 1'b0);
        check_frame("after_short");
        release_frame("after_short");
        $display("test_short_frame done");
    endtask

    task automatic test_long_frame();
        send_frame(790, 0, 1'b0);
        checks++;
        if (frame_valid !== 1'b0) begin fails++; $display("FAIL long_valid frame_valid=%b required 0", frame_valid); end
        send_frame(N_PIX, 1, 1'b0);
        check_frame("after_long");
        release_frame("after_long");
        $display("test_long_frame done");
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            send_frame(N_PIX, 2, 1'b0);
            check_frame("random");
            release_frame("random");
            $display("test_random frame %0d done", f);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(N_PIX, 1, 1'b0);
        for (int i = 0; i < 400; i++) send(pix_t'($urandom), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_frame(N_PIX, 1, 1'b0);
        check_frame("after_reset");
        release_frame("after_reset");
        $display("test_reset_mid_frame done");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_binarise();
        test_short_frame();
        test_long_frame();
        test_random();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
